mvm_job_sched: RTL
==================

MVM_JOB_SCHED -- requirements
Module: mvm_job_sched

Interface
REQ-001 SHALL have parameter K, default 8: matrix dimension (KxK matrix, K-element vectors).
REQ-002 SHALL have parameter B, default 20: input word width; outputs are 2*B.
REQ-003 SHALL have parameter TMO, default 1023: wait-for-done watchdog limit in cycles.
REQ-004 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_load_m in 1: the job header handshake; cmd_load_m=1 means a new matrix precedes the vector.
REQ-007 SHALL have ports in_valid in 1, in_ready out 1, in_data in B: the operand stream (matrix row-major, then vector).
REQ-008 SHALL have ports out_valid out 1, out_ready in 1, out_data out 2*B, out_last out 1: the result stream.
REQ-009 SHALL have ports core_loadMatrix out 1, core_loadVector out 1, core_start out 1, core_data out B: the drive to the MVM core.
REQ-010 SHALL have ports core_done in 1 and core_y in 2*B: the result inputs from the MVM core.
REQ-011 SHALL have ports busy out 1 and err out 1 (a one-cycle error pulse).

Function
REQ-012 SHALL sequence jobs through the states IDLE -> FILL_M -> FILL_V -> LOAD_M -> LOAD_V -> START -> WAIT -> CAPT -> DRAIN -> IDLE.
REQ-013 SHALL skip FILL_M and LOAD_M when cmd_load_m=0.
REQ-014 SHALL drive cmd_ready=1 only in IDLE; a command transfers when cmd_valid and cmd_ready are both 1.
REQ-015 SHALL, when a command arrives with cmd_load_m=0 and no matrix has been loaded since reset, pulse err and stay in IDLE without consuming in_data.
REQ-016 SHALL drive in_ready=1 only in FILL_M (K*K words) and FILL_V (K words); a word is stored when in_valid and in_ready are both 1, and input stalls are permitted.
REQ-017 SHALL hold the operands in internal buffers: a K*K x B matrix buffer and a K x B vector buffer.
REQ-018 SHALL, in LOAD_M, pulse core_loadMatrix in cycle T and drive matrix words 0..K*K-1 on core_data in cycles T+1..T+K*K with no gaps; LOAD_V SHALL do the same for K words using core_loadVector.
REQ-019 SHALL set a sticky matrix-loaded flag at the end of LOAD_M.
REQ-020 SHALL pulse core_start for one cycle in START and then enter WAIT.
REQ-021 SHALL, in WAIT, count cycles; when core_done=1 it enters CAPT.
REQ-022 SHALL, if the WAIT count reaches TMO before core_done, pulse err, clear the matrix-loaded flag, and return to IDLE.
REQ-023 SHALL treat core_done as rising in cycle D and capture core_y in cycles D+1..D+K into output entries 0..K-1, without backpressure.
REQ-024 SHALL, in DRAIN, present entries 0..K-1 in order and assert out_last with entry K-1.
REQ-025 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-026 SHALL return to IDLE on the cycle after the last output transfer.
REQ-027 SHALL ignore a core_done that arrives in any state other than WAIT.
REQ-028 SHALL drive busy=1 in every state except IDLE.
REQ-029 SHALL drive core_data=0 whenever no load is in progress.
REQ-030 SHALL give 8-cycle operand load plus 1-cycle start latency when a job has no new matrix, and 64+8+2 cycles when it has one.

Reset
REQ-031 SHALL, while reset=0, asynchronously force state=IDLE, all counters=0, matrix-loaded=0, and all outputs to 0.
REQ-032 SHALL treat a reset during any state as aborting the job: buffer contents are don't-care, and after release cmd_ready=1 on the first clock edge.

Verification
REQ-033 Bench SHALL cover: cmd with load_m=1, matrix A[i][j]=i+j, vector x=1..8, model core -> core_data shows 64 gapless then 8 gapless words; outputs y[i]=sum_j (i+j)(j+1), out_last on word 7.
REQ-034 Bench SHALL cover: cmd load_m=0 after reset -> err pulse 1 cycle, in_ready stays 0, busy stays 0.
REQ-035 Bench SHALL cover: second job load_m=0 with x=all 2 -> no core_loadMatrix pulse; y[i]=2*rowsum(A).
REQ-036 Bench SHALL cover: in_valid toggled randomly during FILL, and out_ready held 0 for 20 cycles in DRAIN -> no gaps on core_data, out_data stable, no results lost.
REQ-037 Bench SHALL cover: core_done suppressed -> err after TMO=1023 WAIT cycles, IDLE, then a load_m=0 cmd -> err.
REQ-038 Bench SHALL cover: reset asserted in mid-LOAD_M word 30 -> all outputs 0 immediately; after release a full job completes correctly.

Source files
------------

// File: rtl/mvm_job_sched_if.sv
// Job, operand, result and core-drive signals of the MVM job scheduler.
// The master side is the host plus the MVM core; the slave side is the scheduler.
interface mvm_job_sched_if #(
  parameter int B = 20
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_load_m;
  logic           in_valid;
  logic           in_ready;
  logic [B-1:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic [2*B-1:0] out_data;
  logic           out_last;
  logic           core_loadMatrix;
  logic           core_loadVector;
  logic           core_start;
  logic [B-1:0]   core_data;
  logic           core_done;
  logic [2*B-1:0] core_y;
  logic           busy;
  logic           err;

  modport master (
    output cmd_valid, cmd_load_m, in_valid, in_data, out_ready, core_done, core_y,
    input  cmd_ready, in_ready, out_valid, out_data, out_last,
           core_loadMatrix, core_loadVector, core_start, core_data, busy, err
  );

  modport slave (
    input  cmd_valid, cmd_load_m, in_valid, in_data, out_ready, core_done, core_y,
    output cmd_ready, in_ready, out_valid, out_data, out_last,
           core_loadMatrix, core_loadVector, core_start, core_data, busy, err
  );
endinterface

// File: rtl/mvm_job_sched.sv
// Job scheduler for a KxK matrix-vector core: buffers operands, streams them
// into the core, waits for completion with a watchdog and drains the results.
module mvm_job_sched #(
  parameter int K   = 8,
  parameter int B   = 20,
  parameter int TMO = 1023
) (
  input  logic           clk,
  input  logic           reset,
  mvm_job_sched_if.slave bus
);
  localparam int KK   = K * K;
  localparam int MW   = $clog2(KK);
  localparam int VW   = $clog2(K);
  localparam int CMAX = (KK > TMO) ? KK : TMO;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] C_KK   = CW'(KK);
  localparam logic [CW-1:0] C_KK1  = CW'(KK - 1);
  localparam logic [CW-1:0] C_K    = CW'(K);
  localparam logic [CW-1:0] C_K1   = CW'(K - 1);
  localparam logic [CW-1:0] C_TMO1 = CW'(TMO - 1);

  typedef enum logic [3:0] {
    IDLE, FILL_M, FILL_V, LOAD_M, LOAD_V, START, WAIT, CAPT, DRAIN
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            mloaded, job_m, alive;
  logic            set_ml, clr_ml;

  logic [B-1:0]    mbuf [KK];
  logic [B-1:0]    vbuf [K];
  logic [2*B-1:0]  obuf [K];

  // alive holds cmd_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      mloaded <= 1'b0;
      job_m   <= 1'b0;
      alive   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      alive <= 1'b1;
      if (set_ml)      mloaded <= 1'b1;
      else if (clr_ml) mloaded <= 1'b0;
      if (state == IDLE && bus.cmd_valid && alive) job_m <= bus.cmd_load_m;
    end
  end

  // Operand and result buffers carry no reset; their contents are don't-care after abort
  always_ff @(posedge clk) begin
    if (state == FILL_M && bus.in_valid) mbuf[cnt[MW-1:0]] <= bus.in_data;
    if (state == FILL_V && bus.in_valid) vbuf[cnt[VW-1:0]] <= bus.in_data;
    if (state == CAPT)                   obuf[cnt[VW-1:0]] <= bus.core_y;
  end

  always_comb begin
    state_nx            = state;
    cnt_nx              = cnt;
    set_ml              = 1'b0;
    clr_ml              = 1'b0;
    bus.cmd_ready       = 1'b0;
    bus.in_ready        = 1'b0;
    bus.out_valid       = 1'b0;
    bus.out_data        = '0;
    bus.out_last        = 1'b0;
    bus.core_loadMatrix = 1'b0;
    bus.core_loadVector = 1'b0;
    bus.core_start      = 1'b0;
    bus.core_data       = '0;
    bus.err             = 1'b0;
    bus.busy            = (state != IDLE);

    unique case (state)
      IDLE: begin
        bus.cmd_ready = alive;
        cnt_nx        = '0;
        if (bus.cmd_valid && alive) begin
          if (bus.cmd_load_m)  state_nx = FILL_M;
          else if (mloaded)    state_nx = FILL_V;
          else                 bus.err  = 1'b1;
        end
      end
      FILL_M: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if (cnt == C_KK1) begin state_nx = FILL_V; cnt_nx = '0; end
          else cnt_nx = cnt + CW'(1);
        end
      end
      FILL_V: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if (cnt == C_K1) begin
            state_nx = job_m ? LOAD_M : LOAD_V;
            cnt_nx   = '0;
          end else cnt_nx = cnt + CW'(1);
        end
      end
      // Pulse on count 0, then word cnt-1 on each following cycle without gaps
      LOAD_M: begin
        bus.core_loadMatrix = (cnt == '0);
        if (cnt != '0) bus.core_data = mbuf[cnt[MW-1:0] - MW'(1)];
        if (cnt == C_KK) begin
          state_nx = LOAD_V;
          cnt_nx   = '0;
          set_ml   = 1'b1;
        end else cnt_nx = cnt + CW'(1);
      end
      LOAD_V: begin
        bus.core_loadVector = (cnt == '0);
        if (cnt != '0) bus.core_data = vbuf[cnt[VW-1:0] - VW'(1)];
        if (cnt == C_K) begin state_nx = START; cnt_nx = '0; end
        else cnt_nx = cnt + CW'(1);
      end
      START: begin
        bus.core_start = 1'b1;
        state_nx       = WAIT;
        cnt_nx         = '0;
      end
      WAIT: begin
        if (bus.core_done) begin
          state_nx = CAPT;
          cnt_nx   = '0;
        end else if (cnt == C_TMO1) begin
          bus.err  = 1'b1;
          clr_ml   = 1'b1;
          state_nx = IDLE;
          cnt_nx   = '0;
        end else cnt_nx = cnt + CW'(1);
      end
      CAPT: begin
        if (cnt == C_K1) begin state_nx = DRAIN; cnt_nx = '0; end
        else cnt_nx = cnt + CW'(1);
      end
      DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_data  = obuf[cnt[VW-1:0]];
        bus.out_last  = (cnt == C_K1);
        if (bus.out_ready) begin
          if (cnt == C_K1) begin state_nx = IDLE; cnt_nx = '0; end
          else cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end
endmodule
